// File: rtl/lag_pl_occupancy_tracker_pkg.sv
// Shared types for the PL occupancy tracker: per-lane FSM states and the
// occupancy counter width helper.
package lag_pl_occupancy_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } pl_occ_state_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lag_pl_occupancy_tracker_lane.sv
// One PL lane: saturating occupancy counter, packet FSM and release pulse.
// Optional sticky protocol checking is built only when LAG_PL_ERR_CHECK_EN is defined.
module lag_pl_occ_lane
  import lag_pl_occupancy_tracker_pkg::*;
#(
  parameter int buf_depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_head,
  input  logic in_tail,
  input  logic out_valid,
  input  logic out_tail,
  output logic pl_empty,
  output logic pl_release,
  output logic pl_err
);

  localparam int CW = occ_w(buf_depth);
  localparam logic [CW-1:0] FULL = CW'(buf_depth);

  logic [CW-1:0] count;
  pl_occ_state_t state;
  logic          tail_dep;
  logic          head_arr;

  function automatic logic [CW-1:0] sat_step(input logic [CW-1:0] c,
                                             input logic up,
                                             input logic down);
    logic [CW-1:0] r;
    r = c;
    if (up && !down && c != FULL)
      r = c + CW'(1);
    else if (down && !up && c != '0)
      r = c - CW'(1);
    return r;
  endfunction

  assign tail_dep = out_valid & out_tail & (state != IDLE);
  assign head_arr = in_valid & in_head;
  assign pl_empty = (count == '0);

  // A tail departure closes the packet first, so a same-cycle head opens the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      state      <= IDLE;
      pl_release <= 1'b0;
    end else begin
      count      <= sat_step(count, in_valid, out_valid);
      pl_release <= tail_dep;
      if (tail_dep || state == IDLE) begin
        if (head_arr)
          state <= in_tail ? DRAIN : RECV;
        else
          state <= IDLE;
      end else if (state == RECV && in_valid && in_tail) begin
        state <= DRAIN;
      end
    end
  end

`ifdef LAG_PL_ERR_CHECK_EN
  logic err_evt;

  assign err_evt = (in_valid && count == FULL)
                || (out_valid && count == '0)
                || (head_arr && state != IDLE && !tail_dep)
                || (in_valid && !in_head && state == IDLE)
                || (out_valid && out_tail && state == IDLE);

  always_ff @(posedge clk) begin
    if (rst)
      pl_err <= 1'b0;
    else if (err_evt)
      pl_err <= 1'b1;
  end
`else
  assign pl_err = 1'b0;
`endif

endmodule

// File: rtl/lag_pl_occupancy_tracker.sv
// Tracks per-PL buffer occupancy and packet lifetime for one input port.
// Define LAG_PL_ERR_CHECK_EN to build the sticky per-PL protocol error flags.
module lag_pl_occupancy_tracker
  import lag_pl_occupancy_tracker_pkg::*;
#(
  parameter int num_pls   = 4,
  parameter int buf_depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [num_pls-1:0] flit_in_valid,
  input  logic [num_pls-1:0] flit_in_head,
  input  logic [num_pls-1:0] flit_in_tail,
  input  logic [num_pls-1:0] flit_out_valid,
  input  logic [num_pls-1:0] flit_out_tail,
  output logic [num_pls-1:0] pl_empty,
  output logic [num_pls-1:0] pl_release,
  output logic [num_pls-1:0] pl_err
);

  for (genvar i = 0; i < num_pls; i++) begin : g_lane
    lag_pl_occ_lane #(
      .buf_depth(buf_depth)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (flit_in_valid[i]),
      .in_head   (flit_in_head[i]),
      .in_tail   (flit_in_tail[i]),
      .out_valid (flit_out_valid[i]),
      .out_tail  (flit_out_tail[i]),
      .pl_empty  (pl_empty[i]),
      .pl_release(pl_release[i]),
      .pl_err    (pl_err[i])
    );
  end

endmodule

// File: tb/tb_lag_pl_occupancy_tracker.sv
// Bench for lag_pl_occupancy_tracker: directed packet scenarios plus random
// traffic, checked every cycle against a packet-level reference model.
module tb_lag_pl_occupancy_tracker;

  localparam int NP    = 4;
  localparam int DEPTH = 4;
`ifdef LAG_PL_ERR_CHECK_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic          clk;
  logic          rst;
  logic [NP-1:0] flit_in_valid, flit_in_head, flit_in_tail;
  logic [NP-1:0] flit_out_valid, flit_out_tail;
  logic [NP-1:0] pl_empty, pl_release, pl_err;

  lag_pl_occupancy_tracker #(.num_pls(NP), .buf_depth(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .flit_in_valid (flit_in_valid),
    .flit_in_head  (flit_in_head),
    .flit_in_tail  (flit_in_tail),
    .flit_out_valid(flit_out_valid),
    .flit_out_tail (flit_out_tail),
    .pl_empty      (pl_empty),
    .pl_release    (pl_release),
    .pl_err        (pl_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  // Reference model: packet open / tail received flags and a clamped flit count.
  int m_cnt  [NP];
  bit m_open [NP];
  bit m_tin  [NP];
  bit m_rel  [NP];
  bit m_err  [NP];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      for (int i = 0; i < NP; i++) begin
        m_cnt[i] = 0; m_open[i] = 0; m_tin[i] = 0; m_rel[i] = 0; m_err[i] = 0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        int iv, ih, it, ov, ot, tdep, c;
        iv = int'(flit_in_valid[i]); ih = int'(flit_in_head[i]);
        it = int'(flit_in_tail[i]);  ov = int'(flit_out_valid[i]);
        ot = int'(flit_out_tail[i]);
        tdep = (ov != 0 && ot != 0 && m_open[i]) ? 1 : 0;
        if (ERR_EN != 0 &&
            ((iv != 0 && m_cnt[i] == DEPTH) ||
             (ov != 0 && m_cnt[i] == 0) ||
             (iv != 0 && ih != 0 && m_open[i] && tdep == 0) ||
             (iv != 0 && ih == 0 && !m_open[i]) ||
             (ov != 0 && ot != 0 && !m_open[i])))
          m_err[i] = 1;
        m_rel[i] = (tdep != 0);
        if (!m_open[i] || tdep != 0) begin
          m_open[i] = (iv != 0 && ih != 0);
          m_tin[i]  = (iv != 0 && ih != 0 && it != 0);
        end else if (iv != 0 && it != 0) begin
          m_tin[i] = 1;
        end
        c = m_cnt[i] + iv - ov;
        if (c < 0) c = 0;
        if (c > DEPTH) c = DEPTH;
        m_cnt[i] = c;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NP; i++) begin
        chk($sformatf("model_empty[%0d]", i), 32'(pl_empty[i]), 32'(m_cnt[i] == 0));
        chk($sformatf("model_release[%0d]", i), 32'(pl_release[i]), 32'(m_rel[i]));
        chk($sformatf("model_err[%0d]", i), 32'(pl_err[i]), 32'(m_err[i]));
      end
    end
  end

  task automatic cyc(input logic [NP-1:0] iv, input logic [NP-1:0] ih,
                     input logic [NP-1:0] it, input logic [NP-1:0] ov,
                     input logic [NP-1:0] ot);
    flit_in_valid  = iv;
    flit_in_head   = ih;
    flit_in_tail   = it;
    flit_out_valid = ov;
    flit_out_tail  = ot;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    flit_in_valid = '0; flit_in_head = '0; flit_in_tail = '0;
    flit_out_valid = '0; flit_out_tail = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("reset_empty", 32'(pl_empty), 32'hF);
    chk("reset_release", 32'(pl_release), 32'h0);
    chk("reset_err", 32'(pl_err), 32'h0);

    // 3-flit packet on PL1
    cyc(4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
    chk("p1_cnt_a", 32'(m_cnt[1]), 32'd1);
    chk("p1_nonempty", 32'(pl_empty[1]), 32'd0);
    cyc(4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(4'h2, 4'h0, 4'h2, 4'h0, 4'h0);
    chk("p1_cnt_full3", 32'(m_cnt[1]), 32'd3);
    cyc(4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
    cyc(4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
    chk("p1_cnt_b", 32'(m_cnt[1]), 32'd1);
    chk("p1_no_early_rel", 32'(pl_release[1]), 32'd0);
    cyc(4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
    chk("p1_release", 32'(pl_release), 32'h2);
    chk("p1_empty", 32'(pl_empty[1]), 32'd1);
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("p1_release_off", 32'(pl_release), 32'h0);

    // single-flit packet on PL0
    cyc(4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    chk("p0_drain_state", 32'({m_open[0], m_tin[0]}), 32'b11);
    cyc(4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
    chk("p0_release", 32'(pl_release), 32'h1);
    chk("p0_empty", 32'(pl_empty[0]), 32'd1);
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("p0_release_off", 32'(pl_release[0]), 32'd0);

    // back-to-back on PL2
    cyc(4'h4, 4'h4, 4'h0, 4'h0, 4'h0);
    cyc(4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
    cyc(4'h0, 4'h0, 4'h0, 4'h4, 4'h0);
    cyc(4'h4, 4'h4, 4'h0, 4'h4, 4'h4);
    chk("b2b_release", 32'(pl_release), 32'h4);
    chk("b2b_err", 32'(pl_err[2]), 32'd0);
    chk("b2b_cnt", 32'(m_cnt[2]), 32'd1);
    chk("b2b_recv", 32'({m_open[2], m_tin[2]}), 32'b10);
    cyc(4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
    chk("b2b_rel_once", 32'(pl_release[2]), 32'd0);
    cyc(4'h0, 4'h0, 4'h0, 4'h4, 4'h0);
    cyc(4'h0, 4'h0, 4'h0, 4'h4, 4'h4);
    chk("b2b_release2", 32'(pl_release[2]), 32'd1);
    chk("b2b_empty", 32'(pl_empty[2]), 32'd1);

    // overflow on PL3: 5 arrivals, no departures
    cyc(4'h8, 4'h8, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 4; k++) cyc(4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("ovf_cnt_sat", 32'(m_cnt[3]), 32'd4);
    chk("ovf_err", 32'(pl_err[3]), 32'(ERR_EN));
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("ovf_err_hold", 32'(pl_err[3]), 32'(ERR_EN));
    for (int k = 0; k < 4; k++) cyc(4'h0, 4'h0, 4'h0, 4'h8, 4'h0);
    chk("ovf_drained_empty", 32'(pl_empty[3]), 32'd1);
    rst = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    chk("ovf_err_cleared", 32'(pl_err), 32'h0);

    // reset mid-packet on PL1 with count 2 in RECV
    cyc(4'h2, 4'h2, 4'h0, 4'h0, 4'h0);
    cyc(4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("mid_cnt", 32'(m_cnt[1]), 32'd2);
    rst = 1'b1;
    cyc(4'h0, 4'h0, 4'h0, 4'h2, 4'h2);
    rst = 1'b0;
    chk("mid_empty", 32'(pl_empty[1]), 32'd1);
    chk("mid_no_release", 32'(pl_release), 32'h0);
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("mid_no_release2", 32'(pl_release), 32'h0);

    // random traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [NP-1:0] iv, ih, it, ov, ot;
      for (int i = 0; i < NP; i++) begin
        iv[i] = ($urandom_range(0, 99) < 50);
        ih[i] = ($urandom_range(0, 99) < 30);
        it[i] = ($urandom_range(0, 99) < 35);
        ov[i] = ($urandom_range(0, 99) < 45);
        ot[i] = ($urandom_range(0, 99) < 30);
      end
      rst = ($urandom_range(0, 99) == 0);
      cyc(iv, ih, it, ov, ot);
    end
    rst = 1'b0;
    cyc(4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
